// File: rtl/bcd_scan_decoder_if.sv
// Frame-in / scanned-digit-out bus of bcd_scan_decoder.
// The master offers BCD frames; the slave returns the multiplexed digit decode.
interface bcd_scan_decoder_if #(
  parameter int DIGITS = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] in_bcd;
  logic [9:0]          dec_out;
  logic [DIGITS-1:0]   dig_sel;
  logic                out_valid;
  logic                err;
  logic                done;

  modport master (
    output in_valid, in_bcd,
    input  in_ready, dec_out, dig_sel, out_valid, err, done
  );

  modport slave (
    input  in_valid, in_bcd,
    output in_ready, dec_out, dig_sel, out_valid, err, done
  );
endinterface

// File: rtl/bcd_scan_decoder.sv
// Captures a packed BCD frame and scans its digits MSB-first onto a one-hot decode.
// Optional macro BCD_LEADING_ZERO_BLANK_EN blanks zero digits above the first non-zero digit.
module bcd_scan_decoder #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4
) (
  input logic               clk,
  input logic               rst_n,
  bcd_scan_decoder_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [4*DIGITS-1:0] r_frame;
  logic [IDX_W-1:0]    r_idx;
  logic [DIV_W-1:0]    r_div;
  logic                r_drain;
  logic [9:0]          r_dec;
  logic [DIGITS-1:0]   r_sel;
  logic                r_out_valid;
  logic                r_err;
  logic                r_done;

  logic                w_accept;
  logic                w_presenting;
  logic                w_div_term;
  logic                w_last;
  logic                w_bad;
  logic                w_blank;
  logic [3:0]          w_digit;
  logic [9:0]          w_dec_raw;
  logic [DIGITS-1:0]   w_sel;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: each always_comb output is given a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_nxt = SCAN;
      SCAN:    if (r_drain)      w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the counters, so SCAN lasts one extra drain cycle.
  assign w_accept     = (r_state == IDLE) && bus.in_valid;
  assign w_presenting = (r_state == SCAN) && !r_drain;
  assign w_div_term   = (r_div == DIV_TOP);
  assign w_last       = w_div_term && (r_idx == '0);
  assign w_digit      = r_frame[4*int'(r_idx) +: 4];
  assign w_bad        = (w_digit > 4'd9);

  always_comb begin
    w_dec_raw = '0;
    if (!w_bad) w_dec_raw[w_digit] = 1'b1;
  end

  always_comb begin
    w_sel        = '0;
    w_sel[r_idx] = 1'b1;
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  // Blank when this digit and every digit above it are zero; digit 0 always shows.
  always_comb begin
    w_blank = (r_idx != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if ((i >= int'(r_idx)) && (r_frame[4*i +: 4] != 4'd0)) w_blank = 1'b0;
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
      r_idx   <= '0;
      r_div   <= '0;
      r_drain <= 1'b0;
    end else if (w_accept) begin
      r_frame <= bus.in_bcd;
      r_idx   <= IDX_TOP;
      r_div   <= '0;
      r_drain <= 1'b0;
    end else if (w_presenting) begin
      r_div <= w_div_term ? '0 : r_div + DIV_W'(1);
      if (w_div_term) r_idx <= (r_idx == '0) ? IDX_TOP : r_idx - IDX_W'(1);
      if (w_last)     r_drain <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sel       <= '0;
      r_dec       <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= w_presenting;
      r_sel       <= w_presenting ? w_sel : '0;
      r_dec       <= (w_presenting && !w_blank) ? w_dec_raw : '0;
      r_done      <= (r_state == SCAN) && r_drain;
      if (w_accept)                    r_err <= 1'b0;
      else if (w_presenting && w_bad)  r_err <= 1'b1;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.dec_out   = r_dec;
  assign bus.dig_sel   = r_sel;
  assign bus.out_valid = r_out_valid;
  assign bus.err       = r_err;
  assign bus.done      = r_done;

endmodule

// File: doc/bcd_scan_decoder.md
BCD_SCAN_DECODER -- requirements
Module: bcd_scan_decoder

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of 4-bit BCD digits per frame (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 4, clock cycles each digit is presented (legal >=1).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  frame offered on in_bcd.
REQ-006 SHALL have port in_ready  output  1  block can accept a frame.
REQ-007 SHALL have port in_bcd  input  4*DIGITS  packed BCD frame, digit i = in_bcd[4i+3:4i], digit 0 least significant.
REQ-008 SHALL have port dec_out  output  10  registered one-hot decode of the current digit, bit n = value n.
REQ-009 SHALL have port dig_sel  output  DIGITS  registered one-hot index of the current digit.
REQ-010 SHALL have port out_valid  output  1  dec_out/dig_sel are meaningful.
REQ-011 SHALL have port err  output  1  sticky flag: current frame contains a code 10..15.
REQ-012 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, DONE; in_ready=1 only in IDLE.
REQ-014 SHALL accept a frame on a rising edge where in_valid=1 and in_ready=1, capturing in_bcd into an internal frame register and entering SCAN.
REQ-015 SHALL ignore in_valid and in_bcd while in SCAN or DONE; the captured frame is not altered by input changes.
REQ-016 SHALL scan digits most significant first (DIGITS-1 down to 0), each for exactly SCAN_DIV cycles; the first digit appears on the cycle after acceptance.
REQ-017 SHALL drive dec_out with exactly one bit set for codes 0..9 and all-zero for codes 10..15.
REQ-018 SHALL drive dig_sel with exactly one bit set while out_valid=1, and all-zero otherwise.
REQ-019 SHALL set err on the cycle a code 10..15 is first presented, hold it through DONE and IDLE, and clear it on the next acceptance.
REQ-020 SHALL, after the last SCAN_DIV cycle of digit 0, enter DONE for one cycle with done=1, out_valid=0, dec_out=0, dig_sel=0, then return to IDLE.
REQ-021 SHALL give a frame period, acceptance to next in_ready=1, of DIGITS*SCAN_DIV+2 cycles.
REQ-022 SHALL use a divider counter of clog2(SCAN_DIV) bits (min 1) and a digit index of clog2(DIGITS) bits (min 1), both wrapping without overflow at their terminal values.
REQ-023 SHALL, for DIGITS=1 or SCAN_DIV=1, behave per REQ-016..REQ-021 with no extra cycles.

Reset
REQ-024 SHALL, while rst_n=0, immediately force state IDLE and in_ready=1, dec_out=0, dig_sel=0, out_valid=0, err=0, done=0, counters and frame register 0.
REQ-025 SHALL abort any scan in progress on reset assertion; no done pulse is produced for the aborted frame.
REQ-026 SHALL accept the first frame no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL support macro BCD_LEADING_ZERO_BLANK_EN.
REQ-028 SHALL, with BCD_LEADING_ZERO_BLANK_EN defined, output dec_out=0 (dig_sel still asserted, out_valid=1) for zero digits above the most significant non-zero digit; digit 0 is never blanked; a code 10..15 counts as non-zero.
REQ-029 SHALL, without BCD_LEADING_ZERO_BLANK_EN, output dec_out=10'b0000000001 for every zero digit.

Verification (DIGITS=4, SCAN_DIV=2, accept edge = cycle 0)
REQ-030 SHALL verify: in_bcd=16'h1239 -> cycles 1-2 dig_sel=4'b1000 dec_out bit1; 3-4 4'b0100 bit2; 5-6 4'b0010 bit3; 7-8 4'b0001 bit9; cycle 9 done=1; cycle 10 in_ready=1; err=0.
REQ-031 SHALL verify: in_bcd=16'h00A5 -> digit1 (cycles 5-6) dec_out=0, err=1 from cycle 5 until next acceptance; digit0 dec_out bit5.
REQ-032 SHALL verify: in_bcd=16'h0007 -> with BCD_LEADING_ZERO_BLANK_EN cycles 1-6 dec_out=0, cycles 7-8 bit7; without it cycles 1-6 dec_out=10'b0000000001.
REQ-033 SHALL verify: in_valid held high with changing in_bcd during cycles 1-9 -> no re-acceptance, output follows frame captured at cycle 0, second frame accepted at cycle 10.
REQ-034 SHALL verify: rst_n pulsed low at cycle 4 mid-frame -> all outputs at reset values without waiting for a clock edge, no done pulse, in_ready=1.
REQ-035 SHALL verify: in_bcd=16'h0000 with BCD_LEADING_ZERO_BLANK_EN -> cycles 1-6 dec_out=0, cycles 7-8 dec_out=10'b0000000001.
